// File: rtl/key_entry_pkg.sv
// Key entry buffer shared types and constants.
// FSM states, digit limit and default geometry.
package key_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL
  } state_t;

  localparam int DIGIT_MAX      = 9;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int DIGIT_W_DEF    = 4;

endpackage

// File: rtl/key_digit_check.sv
// Combinational decimal-digit qualifier for keys.
// Used only when KEY_ENTRY_DIGIT_CHECK_EN is defined.
module key_digit_check
  import key_entry_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic [DIGIT_W-1:0] key,
  output logic               accept
);

  // Accept only keys in the decimal range 0..DIGIT_MAX.
  assign accept = (32'(key) <= 32'(DIGIT_MAX));

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer with backspace, clear and commit.
// KEY_ENTRY_DIGIT_CHECK_EN: reject keys above 9.
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIGIT_W    = DIGIT_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            shift,
  input  logic [DIGIT_W-1:0]              key,
  input  logic                            backspace,
  input  logic                            clear,
  input  logic                            commit,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   key_buffer,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   committed_buffer,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            full,
  output logic                            entry_valid,
  output logic                            entry_error
);

  localparam int BW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  state_t          state;
  state_t          state_n;
  logic [BW-1:0]   buf_n;
  logic [BW-1:0]   cbuf_n;
  logic [CW-1:0]   cnt_n;
  logic            valid_n;
  logic            error_n;
  logic            key_ok;
  logic            do_clear;
  logic            do_commit;
  logic            do_bs;
  logic            do_shift;

`ifdef KEY_ENTRY_DIGIT_CHECK_EN
  key_digit_check #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_check (
    .key    (key),
    .accept (key_ok)
  );
`else
  assign key_ok = 1'b1;
`endif

  assign do_clear  = clear;
  assign do_commit = commit & ~clear;
  assign do_bs     = backspace & ~clear & ~commit;
  assign do_shift  = shift & ~clear & ~commit
                   & ~backspace;

  assign full = (state == FULL);

  // Next entry, count, state and pulses by priority.
  always_comb begin
    state_n = state;
    buf_n   = key_buffer;
    cbuf_n  = committed_buffer;
    cnt_n   = digit_count;
    valid_n = 1'b0;
    error_n = 1'b0;
    unique case (1'b1)
      do_clear: begin
        buf_n   = '0;
        cnt_n   = '0;
        state_n = EMPTY;
      end
      do_commit: begin
        if (state == FULL) begin
          cbuf_n  = key_buffer;
          valid_n = 1'b1;
          buf_n   = '0;
          cnt_n   = '0;
          state_n = EMPTY;
        end else begin
          error_n = 1'b1;
        end
      end
      do_bs: begin
        if (state != EMPTY) begin
          buf_n = {{DIGIT_W{1'b0}},
                   key_buffer[BW-1:DIGIT_W]};
          cnt_n = digit_count - CW'(1);
          state_n = (digit_count == CW'(1))
                  ? EMPTY : ENTRY;
        end
      end
      do_shift: begin
        if (!key_ok) begin
          error_n = 1'b1;
        end else begin
          buf_n = {key_buffer[BW-DIGIT_W-1:0],
                   key};
          if (state != FULL) begin
            cnt_n = digit_count + CW'(1);
            state_n = (cnt_n == CW'(NUM_DIGITS))
                    ? FULL : ENTRY;
          end
        end
      end
      default: ;
    endcase
  end

  // Register state and all outputs; reset clears all.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= EMPTY;
      key_buffer       <= '0;
      committed_buffer <= '0;
      digit_count      <= '0;
      entry_valid      <= 1'b0;
      entry_error      <= 1'b0;
    end else begin
      state            <= state_n;
      key_buffer       <= buf_n;
      committed_buffer <= cbuf_n;
      digit_count      <= cnt_n;
      entry_valid      <= valid_n;
      entry_error      <= error_n;
    end
  end

endmodule
